// File: rtl/comp16_pkg.sv
// Shared widths and helpers for the comp16 envelope compressor.
package comp16_pkg;
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 8;
  localparam int COEF_FRAC  = 4;
  localparam logic [COEF_W-1:0] COEF_UNITY = 8'h10;
  localparam int TBL_DEPTH  = 64;
  localparam int TBL_AW     = 6;
  localparam int LATENCY    = 12;
  localparam int MUL_CYCLES = 8;
  localparam int PROD_W     = DATA_W + COEF_W;
  localparam int MUL_START  = LATENCY - MUL_CYCLES;

  // |v| clamped to 15 bits so -32768 maps to 32767
  function automatic logic [DATA_W-2:0] sat_abs(input logic signed [DATA_W-1:0] v);
    if (v == 16'sh8000) return 15'h7FFF;
    else if (v[DATA_W-1]) return 15'(-v);
    else return v[DATA_W-2:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-COEF_FRAC-1:0] s;
    s = (PROD_W-COEF_FRAC)'(p >>> COEF_FRAC);
    if (s > 20'sd32767) return 16'sh7FFF;
    else if (s < -20'sd32768) return 16'sh8000;
    else return s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/comp16_smul.sv
// Signed 16 x unsigned 8 shift-add multiplier, one coefficient bit per clock, LSB first.
module comp16_smul
  import comp16_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] a,
  input  logic [COEF_W-1:0]        b,
  output logic signed [PROD_W-1:0] p,
  output logic                     done
);
  logic signed [PROD_W-1:0] a_sh;
  logic signed [PROD_W-1:0] a_ext;
  logic [COEF_W-1:0]        b_sh;
  logic [2:0]               k;
  logic                     busy;

  assign a_ext = {{COEF_W{a[DATA_W-1]}}, a};

  // the start edge already consumes bit 0, so seven more edges finish the product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p    <= '0;
      a_sh <= '0;
      b_sh <= '0;
      k    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p    <= b[0] ? a_ext : '0;
        a_sh <= a_ext <<< 1;
        b_sh <= b >> 1;
        k    <= 3'd1;
        busy <= 1'b1;
      end else if (busy) begin
        p    <= p + (b_sh[0] ? a_sh : '0);
        a_sh <= a_sh <<< 1;
        b_sh <= b_sh >> 1;
        k    <= k + 3'd1;
        if (k == 3'(MUL_CYCLES-1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/comp16_compressor.sv
// Complex-sample compressor: envelope estimate, 64-entry gain curve lookup, serial scaling of X and Y.
module comp16_compressor
  import comp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dix,
  input  logic [DATA_W-1:0] diy,
  input  logic              iv,
  output logic [DATA_W-1:0] dox,
  output logic [DATA_W-1:0] doy,
  output logic              ov,
  input  logic [COEF_W-1:0] cin,
  input  logic              cwe
);
  logic [3:0]               cnt;
  logic                     accept;
  logic signed [DATA_W-1:0] xr, yr;
  logic [DATA_W-2:0]        ax, ay, mx, mn;
  logic [6:0]               sum_hi;
  logic [TBL_AW-1:0]        m_hi;
  logic [TBL_AW-1:0]        wp;
  logic [COEF_W-1:0]        g;
  logic [COEF_W-1:0]        tbl [TBL_DEPTH];
  logic signed [PROD_W-1:0] px, py;
  logic                     done_x, done_y;

  // the slot that delivers a result is also free to take the next sample
  assign accept = iv && (cnt == 4'd0 || cnt == 4'(LATENCY));

  assign mx     = (ax >= ay) ? ax : ay;
  assign mn     = (ax >= ay) ? ay : ax;
  assign sum_hi = 7'(({1'b0, mx} + 16'(mn >> 2)) >> 9);

  always_ff @(posedge clk) begin
    if (cwe) tbl[wp] <= cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wp   <= '0;
      xr   <= '0;
      yr   <= '0;
      ax   <= '0;
      ay   <= '0;
      m_hi <= '0;
      g    <= '0;
      dox  <= '0;
      doy  <= '0;
      ov   <= 1'b0;
    end else begin
      ov <= 1'b0;
      if (cwe) wp <= wp + 1'b1;
      if (accept) begin
        cnt <= 4'd1;
        xr  <= dix;
        yr  <= diy;
      end else if (cnt == 4'(LATENCY)) cnt <= '0;
      else if (cnt != 4'd0) cnt <= cnt + 4'd1;
      if (cnt == 4'd1) begin
        ax <= sat_abs(xr);
        ay <= sat_abs(yr);
      end
      // saturated magnitude only matters through its top six bits
      if (cnt == 4'd2) m_hi <= sum_hi[6] ? 6'h3F : sum_hi[5:0];
      if (cnt == 4'(MUL_START-1)) g <= tbl[~m_hi];
      if (cnt == 4'(LATENCY) && done_x && done_y) begin
        dox <= sat_out(px);
        doy <= sat_out(py);
        ov  <= 1'b1;
      end
    end
  end

  comp16_smul u_mul_x (
    .clk(clk), .rst(rst), .start(cnt == 4'(MUL_START)), .a(xr), .b(g), .p(px), .done(done_x)
  );
  comp16_smul u_mul_y (
    .clk(clk), .rst(rst), .start(cnt == 4'(MUL_START)), .a(yr), .b(g), .p(py), .done(done_y)
  );
endmodule

// File: tb/tb_comp16_compressor.sv
// Directed and randomized bench for comp16_compressor with an arithmetic reference model.
module tb_comp16_compressor;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dix, diy;
  logic        iv, cwe;
  logic [7:0]  cin;
  logic [15:0] dox, doy;
  logic        ov;

  int checks = 0;
  int errors = 0;
  logic [7:0] mtbl [64];
  int mwp = 0;

  comp16_compressor dut (
    .clk(clk), .rst(rst), .dix(dix), .diy(diy), .iv(iv),
    .dox(dox), .doy(doy), .ov(ov), .cin(cin), .cwe(cwe)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] v);
    cin = v;
    cwe = 1'b1;
    tick();
    cwe = 1'b0;
    mtbl[mwp] = v;
    mwp = (mwp + 1) % 64;
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void ref_out(input int x, input int y, output int ex, output int ey);
    int ax, ay, m, g;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    m = (ax > ay) ? ax + ay / 4 : ay + ax / 4;
    if (m > 32767) m = 32767;
    g = int'(mtbl[63 - m / 512]);
    ex = sat((x * g) >>> 4);
    ey = sat((y * g) >>> 4);
  endfunction

  task automatic send(input int x, input int y, input int ex, input int ey, input string tag);
    int lat;
    dix = 16'(x);
    diy = 16'(y);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ov) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, lat, 12);
    chk({tag, " dox"}, $signed(dox), ex);
    chk({tag, " doy"}, $signed(doy), ey);
    tick();
    chk({tag, " ov width"}, {31'd0, ov}, 0);
    repeat (18) tick();
  endtask

  initial begin
    int cv [6] = '{1023, 2047, 4095, 8191, 16383, 32767};
    int ce [6] = '{8184, 16376, 32760, 32764, 32766, 32767};
    int x, y, ex, ey, lat, ovn, c1, c2, v1, v2;

    rst = 1'b1; iv = 1'b0; cwe = 1'b0; cin = '0; dix = '0; diy = '0;
    repeat (3) tick();
    chk("reset dox", $signed(dox), 0);
    chk("reset doy", $signed(doy), 0);
    chk("reset ov", {31'd0, ov}, 0);
    rst = 1'b0;
    tick();

    // unity curve, wrapping ramp on X
    for (int i = 0; i < 64; i++) wr(8'h10);
    for (int k = 0; k < 256; k++) begin
      x = k * 256;
      if (x > 32767) x -= 65536;
      send(x, 0, x, 0, "unity");
    end

    // stepped curve
    for (int i = 0; i < 64; i++) wr(i < 32 ? 8'h10 : i < 48 ? 8'h20 : i < 56 ? 8'h40 : 8'h80);
    for (int i = 0; i < 6; i++) begin
      send(cv[i], 0, ce[i], 0, "curve +x");
      send(-cv[i], 0, -ce[i], 0, "curve -x");
      send(0, cv[i], 0, ce[i], "curve +y");
      send(0, -cv[i], 0, -ce[i], "curve -y");
    end

    // saturation
    for (int i = 0; i < 64; i++) wr(8'hFF);
    send(32767, 0, 32767, 0, "sat pos");
    send(-32768, 0, -32768, 0, "sat neg");
    send(0, -32768, 0, -32768, "sat neg y");

    // random curve and samples
    for (int i = 0; i < 64; i++) wr(8'($urandom));
    for (int n = 0; n < 40; n++) begin
      x = int'($signed(16'($urandom)));
      y = int'($signed(16'($urandom)));
      if ($urandom_range(0, 1) == 1) x = x >>> $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) y = y >>> $urandom_range(0, 12);
      ref_out(x, y, ex, ey);
      send(x, y, ex, ey, "random");
    end

    // busy rule
    for (int i = 0; i < 64; i++) wr(8'h10);
    ovn = 0; c1 = -1; c2 = -1; v1 = 0; v2 = 0;
    for (int c = 0; c <= 30; c++) begin
      iv = (c == 0 || c == 5 || c == 12);
      dix = (c == 0) ? 16'd100 : (c == 5) ? 16'd200 : 16'd300;
      diy = '0;
      tick();
      if (ov) begin
        ovn++;
        if (c1 < 0) begin c1 = c; v1 = $signed(dox); end
        else if (c2 < 0) begin c2 = c; v2 = $signed(dox); end
      end
    end
    iv = 1'b0;
    chk("busy ov count", ovn, 2);
    chk("busy first cycle", c1, 12);
    chk("busy first value", v1, 100);
    chk("busy second cycle", c2, 24);
    chk("busy second value", v2, 300);
    repeat (10) tick();

    // pointer wrap: 70 writes, entries 0-5 get the last six
    for (int j = 0; j < 70; j++) wr(j < 64 ? 8'h10 : 8'(5 + 2 * (j - 64)));
    for (int i = 0; i < 6; i++) begin
      x = (63 - i) * 512;
      send(x, 0, (x * (5 + 2 * i)) >>> 4, 0, "wrap entry");
    end
    send(57 * 512, 0, 57 * 512, 0, "wrap entry6");

    // reset mid-multiply
    dix = 16'd1000; diy = 16'd1000;
    iv = 1'b1;
    tick();
    iv = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("midrst dox", $signed(dox), 0);
    chk("midrst doy", $signed(doy), 0);
    chk("midrst ov", {31'd0, ov}, 0);
    tick();
    rst = 1'b0;
    mwp = 0;
    ovn = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ov) ovn++;
    end
    chk("midrst no ov", ovn, 0);
    wr(8'h0C);
    send(32767, 0, 24575, 0, "post rst entry0");

    // write on the lookup edge: old data is read, new data next time
    dix = 16'd31744; diy = '0;
    iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    cin = 8'h20;
    cwe = 1'b1;
    tick();
    cwe = 1'b0;
    lat = -1;
    for (int k = 4; k <= 20; k++) begin
      tick();
      if (ov) begin
        lat = k;
        break;
      end
    end
    chk("rdwr latency", lat, 12);
    chk("rdwr old data", $signed(dox), 13888);
    repeat (20) tick();
    send(31744, 0, 32767, 0, "rdwr new data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
